// File: rtl/wb_apb_bridge_if.sv
// rtl/wb_apb_bridge_if.sv - Wishbone slave side and APB master side signal bundle of the bridge
interface wb_apb_bridge_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0]            wb_adr;
    logic [DATA_W-1:0]            wb_dat_w;
    logic [DATA_W-1:0]            wb_dat_r;
    logic                         wb_we;
    logic [SEL_W-1:0]             wb_sel;
    logic                         wb_cyc;
    logic                         wb_stb;
    logic                         wb_ack;
    logic                         wb_err;
    logic [ADDR_W-1:0]            paddr;
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [DATA_W-1:0]            pwdata;
    logic [SEL_W-1:0]             pstrb;
    logic [2:0]                   pprot;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport slave (
        input  wb_adr, wb_dat_w, wb_we, wb_sel, wb_cyc, wb_stb,
        input  prdata, pready, pslverr,
        output wb_dat_r, wb_ack, wb_err,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );

    modport master (
        output wb_adr, wb_dat_w, wb_we, wb_sel, wb_cyc, wb_stb,
        output prdata, pready, pslverr,
        input  wb_dat_r, wb_ack, wb_err,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/wb_apb_bridge.sv
// rtl/wb_apb_bridge.sv - Wishbone classic slave to APB4 master bridge with slave decode and access timeout
module wb_apb_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 255
) (
    input logic            clk,
    input logic            rst_n,
    wb_apb_bridge_if.slave bus
);
    localparam int SEL_W  = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int IDXP_W = IDX_W + 1;
    localparam int NPAD   = 1 << IDX_W;
    localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_L  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [IDXP_W-1:0]     NS_LIM   = IDXP_W'(NUM_SLAVES);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TMO_L);
    localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);
    localparam logic [NUM_SLAVES-1:0] SEL_ONE  = NUM_SLAVES'(1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      adr_q, adr_d;
    logic [DATA_W-1:0]      wdat_q, wdat_d;
    logic [DATA_W-1:0]      rdat_q, rdat_d;
    logic                   we_q, we_d;
    logic [SEL_W-1:0]       strb_q, strb_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       wb_idx;
    logic [NUM_SLAVES-1:0]  psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   resp_en_q, resp_en_d;
    logic                   fail;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [NPAD-1:0]        rdy_pad, slverr_pad;
    logic [NPAD*DATA_W-1:0] rdata_pad;

    assign wb_idx = bus.wb_adr[SLV_LSB +: IDX_W];

    // Widen per-slave inputs to a power of two so any idx value indexes safely
    always_comb begin
        rdy_pad                              = '0;
        slverr_pad                           = '0;
        rdata_pad                            = '0;
        rdy_pad[NUM_SLAVES-1:0]              = bus.pready;
        slverr_pad[NUM_SLAVES-1:0]           = bus.pslverr;
        rdata_pad[NUM_SLAVES*DATA_W-1:0]     = bus.prdata;
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        we_d      = we_q;
        strb_d    = strb_q;
        idx_d     = idx_q;
        resp_en_d = resp_en_q;
        tmo_d     = tmo_q;
        fail      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wb_cyc && bus.wb_stb) begin
                    adr_d     = bus.wb_adr;
                    we_d      = bus.wb_we;
                    idx_d     = wb_idx;
                    resp_en_d = 1'b1;
                    strb_d    = bus.wb_we ? bus.wb_sel : '0;
                    if (bus.wb_we) begin
                        wdat_d = bus.wb_dat_w;
                    end
                    if ({1'b0, wb_idx} < NS_LIM) begin
                        state_d = SETUP;
                        tmo_d   = '0;
                    end else begin
                        state_d = RESP;
                        fail    = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (!bus.wb_cyc) begin
                    resp_en_d = 1'b0;
                end
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!bus.wb_cyc) begin
                    resp_en_d = 1'b0;
                end
                if (rdy_pad[idx_q]) begin
                    fail = slverr_pad[idx_q];
                    if (!we_q) begin
                        rdat_d = slverr_pad[idx_q] ? '0 : rdata_pad[idx_q*DATA_W +: DATA_W];
                    end
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    fail = 1'b1;
                    if (!we_q) begin
                        rdat_d = '0;
                    end
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            RESP: begin
                resp_en_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        psel_d    = ((state_d == SETUP) || (state_d == ACCESS)) ? (SEL_ONE << idx_d) : '0;
        penable_d = (state_d == ACCESS);
        ack_d     = (state_d == RESP) && resp_en_d && !fail;
        err_d     = (state_d == RESP) && resp_en_d && fail;
    end

    // State and output registers; reset drops everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            we_q      <= 1'b0;
            strb_q    <= '0;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            resp_en_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            we_q      <= we_d;
            strb_q    <= strb_d;
            idx_q     <= idx_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            resp_en_q <= resp_en_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.wb_dat_r = rdat_q;
    assign bus.wb_ack   = ack_q;
    assign bus.wb_err   = err_q;
    assign bus.paddr    = adr_q;
    assign bus.psel     = psel_q;
    assign bus.penable  = penable_q;
    assign bus.pwrite   = we_q;
    assign bus.pwdata   = wdat_q;
    assign bus.pstrb    = strb_q;
    assign bus.pprot    = 3'b000;
endmodule

// File: tb/tb_wb_apb_bridge.sv
// tb/tb_wb_apb_bridge.sv - directed self-checking bench for wb_apb_bridge
module tb_wb_apb_bridge;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    wb_apb_bridge_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) ia ();
    wb_apb_bridge_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) ib ();

    wb_apb_bridge #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SLV_LSB(12), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave)
    );
    wb_apb_bridge #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .SLV_LSB(12), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave)
    );

    task automatic start_a(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk);
        ia.wb_adr = adr; ia.wb_we = we; ia.wb_dat_w = dat; ia.wb_sel = sel;
        ia.wb_cyc = 1'b1; ia.wb_stb = 1'b1;
    endtask

    task automatic end_a();
        ia.wb_cyc = 1'b0; ia.wb_stb = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (ia.psel !== 4'b0000) $display("FAIL rst_psel got=%b exp=0000", ia.psel); else passed++;
        total++; if ({ia.penable, ia.pwrite, ia.wb_ack, ia.wb_err} !== 4'b0000) $display("FAIL rst_ctl got=%b exp=0000", {ia.penable, ia.pwrite, ia.wb_ack, ia.wb_err}); else passed++;
        total++; if (ia.paddr !== 32'h0) $display("FAIL rst_paddr got=%h exp=0", ia.paddr); else passed++;
        total++; if (ia.pwdata !== 32'h0) $display("FAIL rst_pwdata got=%h exp=0", ia.pwdata); else passed++;
        total++; if (ia.pstrb !== 4'b0000) $display("FAIL rst_pstrb got=%b exp=0000", ia.pstrb); else passed++;
        total++; if (ia.wb_dat_r !== 32'h0) $display("FAIL rst_dat_r got=%h exp=0", ia.wb_dat_r); else passed++;
        total++; if (ia.pprot !== 3'b000) $display("FAIL rst_pprot got=%b exp=000", ia.pprot); else passed++;
        total++; if ({ib.psel, ib.wb_err} !== 4'b0000) $display("FAIL rst_b got=%b exp=0000", {ib.psel, ib.wb_err}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        start_a(32'h0000_1004, 1'b1, 32'hCAFE_F00D, 4'b0011);
        @(negedge clk);
        total++; if (ia.psel !== 4'b0010) $display("FAIL wr_c1_psel got=%b exp=0010", ia.psel); else passed++;
        total++; if (ia.penable !== 1'b0) $display("FAIL wr_c1_penable got=%b exp=0", ia.penable); else passed++;
        total++; if (ia.paddr !== 32'h0000_1004) $display("FAIL wr_c1_paddr got=%h exp=00001004", ia.paddr); else passed++;
        total++; if (ia.pwrite !== 1'b1) $display("FAIL wr_c1_pwrite got=%b exp=1", ia.pwrite); else passed++;
        total++; if (ia.pwdata !== 32'hCAFE_F00D) $display("FAIL wr_c1_pwdata got=%h exp=cafef00d", ia.pwdata); else passed++;
        total++; if (ia.pstrb !== 4'b0011) $display("FAIL wr_c1_pstrb got=%b exp=0011", ia.pstrb); else passed++;
        @(negedge clk);
        total++; if ({ia.psel, ia.penable, ia.wb_ack} !== 6'b0010_1_0) $display("FAIL wr_c2_access got=%b exp=001010", {ia.psel, ia.penable, ia.wb_ack}); else passed++;
        @(negedge clk);
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b10) $display("FAIL wr_c3_ack got=%b exp=10", {ia.wb_ack, ia.wb_err}); else passed++;
        total++; if ({ia.psel, ia.penable} !== 5'b0) $display("FAIL wr_c3_idle got=%b exp=00000", {ia.psel, ia.penable}); else passed++;
        end_a();
        @(negedge clk);
        total++; if (ia.wb_ack !== 1'b0) $display("FAIL wr_c4_ack_pulse got=%b exp=0", ia.wb_ack); else passed++;
    endtask

    task automatic test_read_wait();
        ia.pready = 4'b1011;
        start_a(32'h0000_2000, 1'b0, 32'h0, 4'b1111);
        @(negedge clk);
        total++; if (ia.psel !== 4'b0100) $display("FAIL rd_c1_psel got=%b exp=0100", ia.psel); else passed++;
        total++; if ({ia.pwrite, ia.pstrb} !== 5'b0) $display("FAIL rd_c1_dir_strb got=%b exp=00000", {ia.pwrite, ia.pstrb}); else passed++;
        total++; if (ia.pwdata !== 32'hCAFE_F00D) $display("FAIL rd_c1_pwdata_hold got=%h exp=cafef00d", ia.pwdata); else passed++;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            total++; if ({ia.penable, ia.wb_ack} !== 2'b10) $display("FAIL rd_c%0d_wait got=%b exp=10", c, {ia.penable, ia.wb_ack}); else passed++;
        end
        ia.pready = 4'b1111;
        @(negedge clk);
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b10) $display("FAIL rd_c5_ack got=%b exp=10", {ia.wb_ack, ia.wb_err}); else passed++;
        total++; if (ia.wb_dat_r !== 32'h1234_5678) $display("FAIL rd_c5_data got=%h exp=12345678", ia.wb_dat_r); else passed++;
        end_a();
    endtask

    task automatic test_read_err();
        ia.pslverr = 4'b0001;
        start_a(32'h0000_0008, 1'b0, 32'h0, 4'b1111);
        @(negedge clk);
        total++; if (ia.psel !== 4'b0001) $display("FAIL rerr_c1_psel got=%b exp=0001", ia.psel); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b01) $display("FAIL rerr_c3_err got=%b exp=01", {ia.wb_ack, ia.wb_err}); else passed++;
        total++; if (ia.wb_dat_r !== 32'h0) $display("FAIL rerr_c3_data got=%h exp=0", ia.wb_dat_r); else passed++;
        end_a();
        ia.pslverr = 4'b0000;
        @(negedge clk);
        total++; if (ia.wb_err !== 1'b0) $display("FAIL rerr_c4_pulse got=%b exp=0", ia.wb_err); else passed++;
    endtask

    task automatic test_timeout_back_to_back();
        ia.pready = 4'b0111;
        start_a(32'h0000_3000, 1'b0, 32'h0, 4'b1111);
        @(negedge clk);
        total++; if ({ia.psel, ia.penable} !== 5'b1000_0) $display("FAIL to_c1_setup got=%b exp=10000", {ia.psel, ia.penable}); else passed++;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            total++; if ({ia.psel, ia.penable, ia.wb_err} !== 6'b1000_1_0) $display("FAIL to_c%0d_access got=%b exp=100010", c, {ia.psel, ia.penable, ia.wb_err}); else passed++;
        end
        @(negedge clk);
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b01) $display("FAIL to_c6_err got=%b exp=01", {ia.wb_ack, ia.wb_err}); else passed++;
        total++; if ({ia.psel, ia.penable} !== 5'b0) $display("FAIL to_c6_release got=%b exp=00000", {ia.psel, ia.penable}); else passed++;
        ia.wb_adr = 32'h0000_1000;
        ia.pready = 4'b1111;
        @(negedge clk);
        total++; if ({ia.psel, ia.wb_err} !== 5'b0) $display("FAIL b2b_c7_idle got=%b exp=00000", {ia.psel, ia.wb_err}); else passed++;
        @(negedge clk);
        total++; if (ia.psel !== 4'b0010) $display("FAIL b2b_c8_psel got=%b exp=0010", ia.psel); else passed++;
        @(negedge clk);
        total++; if (ia.penable !== 1'b1) $display("FAIL b2b_c9_penable got=%b exp=1", ia.penable); else passed++;
        @(negedge clk);
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b10) $display("FAIL b2b_c10_ack got=%b exp=10", {ia.wb_ack, ia.wb_err}); else passed++;
        total++; if (ia.wb_dat_r !== 32'hDEAD_BEEF) $display("FAIL b2b_c10_data got=%h exp=deadbeef", ia.wb_dat_r); else passed++;
        end_a();
    endtask

    task automatic test_write_keeps_rdata();
        start_a(32'h0000_0010, 1'b1, 32'h1111_2222, 4'b1111);
        @(negedge clk);
        total++; if ({ia.psel, ia.pstrb} !== 8'b0001_1111) $display("FAIL wk_c1_psel_strb got=%b exp=00011111", {ia.psel, ia.pstrb}); else passed++;
        repeat (2) @(negedge clk);
        total++; if (ia.wb_ack !== 1'b1) $display("FAIL wk_c3_ack got=%b exp=1", ia.wb_ack); else passed++;
        total++; if (ia.wb_dat_r !== 32'hDEAD_BEEF) $display("FAIL wk_c3_data_hold got=%h exp=deadbeef", ia.wb_dat_r); else passed++;
        end_a();
    endtask

    task automatic test_decode_err();
        @(negedge clk);
        ib.wb_adr = 32'h0000_3000; ib.wb_we = 1'b0; ib.wb_cyc = 1'b1; ib.wb_stb = 1'b1;
        @(negedge clk);
        total++; if ({ib.wb_ack, ib.wb_err} !== 2'b01) $display("FAIL dec_c1_err got=%b exp=01", {ib.wb_ack, ib.wb_err}); else passed++;
        total++; if (ib.psel !== 3'b000) $display("FAIL dec_c1_psel got=%b exp=000", ib.psel); else passed++;
        ib.wb_cyc = 1'b0; ib.wb_stb = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            total++; if ({ib.psel, ib.penable, ib.wb_err} !== 5'b0) $display("FAIL dec_c%0d_quiet got=%b exp=00000", c, {ib.psel, ib.penable, ib.wb_err}); else passed++;
        end
    endtask

    task automatic test_cyc_drop();
        ia.pready = 4'b1011;
        start_a(32'h0000_2004, 1'b0, 32'h0, 4'b1111);
        @(negedge clk);
        total++; if (ia.psel !== 4'b0100) $display("FAIL cd_c1_psel got=%b exp=0100", ia.psel); else passed++;
        @(negedge clk);
        end_a();
        repeat (2) @(negedge clk);
        total++; if ({ia.psel, ia.penable} !== 5'b0100_1) $display("FAIL cd_c4_apb_busy got=%b exp=01001", {ia.psel, ia.penable}); else passed++;
        @(negedge clk);
        total++; if ({ia.psel, ia.penable} !== 5'b0100_1) $display("FAIL cd_c5_apb_busy got=%b exp=01001", {ia.psel, ia.penable}); else passed++;
        ia.pready = 4'b1111;
        @(negedge clk);
        total++; if ({ia.psel, ia.penable} !== 5'b0) $display("FAIL cd_c6_release got=%b exp=00000", {ia.psel, ia.penable}); else passed++;
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b00) $display("FAIL cd_c6_no_resp got=%b exp=00", {ia.wb_ack, ia.wb_err}); else passed++;
        @(negedge clk);
        total++; if ({ia.wb_ack, ia.wb_err} !== 2'b00) $display("FAIL cd_c7_no_resp got=%b exp=00", {ia.wb_ack, ia.wb_err}); else passed++;
    endtask

    task automatic test_reset_mid();
        ia.pready = 4'b1011;
        start_a(32'h0000_2008, 1'b1, 32'h5555_AAAA, 4'b1100);
        repeat (2) @(negedge clk);
        total++; if ({ia.psel, ia.penable} !== 5'b0100_1) $display("FAIL rm_c2_access got=%b exp=01001", {ia.psel, ia.penable}); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({ia.psel, ia.penable, ia.pwrite, ia.wb_ack, ia.wb_err} !== 8'b0) $display("FAIL rm_async_ctl got=%b exp=00000000", {ia.psel, ia.penable, ia.pwrite, ia.wb_ack, ia.wb_err}); else passed++;
        total++; if ({ia.paddr, ia.pwdata} !== 64'h0) $display("FAIL rm_async_addr_data got=%h exp=0", {ia.paddr, ia.pwdata}); else passed++;
        total++; if ({ia.pstrb, ia.wb_dat_r} !== 36'h0) $display("FAIL rm_async_strb_rdata got=%h exp=0", {ia.pstrb, ia.wb_dat_r}); else passed++;
        end_a();
        @(negedge clk);
        rst_n = 1'b1;
        ia.pready = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if ({ia.wb_ack, ia.wb_err, ia.psel} !== 6'b0) $display("FAIL rm_after_%0d got=%b exp=000000", c, {ia.wb_ack, ia.wb_err, ia.psel}); else passed++;
        end
    endtask

    initial begin
        ia.wb_adr = '0; ia.wb_dat_w = '0; ia.wb_we = 1'b0; ia.wb_sel = '0;
        ia.wb_cyc = 1'b0; ia.wb_stb = 1'b0;
        ia.prdata  = {32'hBAD0_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'hAAAA_5555};
        ia.pready  = 4'b1111;
        ia.pslverr = 4'b0000;
        ib.wb_adr = '0; ib.wb_dat_w = '0; ib.wb_we = 1'b0; ib.wb_sel = '0;
        ib.wb_cyc = 1'b0; ib.wb_stb = 1'b0;
        ib.prdata  = '0;
        ib.pready  = 3'b111;
        ib.pslverr = 3'b000;

        test_reset();
        test_write();
        test_read_wait();
        test_read_err();
        test_timeout_back_to_back();
        test_write_keeps_rdata();
        test_decode_err();
        test_cyc_drop();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
